// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MIPS multiply/divide sequencer owning HI/LO; stalls the pipe while busy.
// Define HILO_FWD_EN to bypass accepted MTHI/MTLO data straight onto hi_o/lo_o.
module muldiv_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic        signed_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] hilo_wdata,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = $clog2(DIV_CYCLES);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_nx;
    logic [31:0] hi, lo, a, b, rem, quot, rem_nx, quot_nx, abs_a, abs_b;
    logic [63:0] prod;
    logic [32:0] shl, sub;
    logic [CW-1:0] cnt;
    logic sgn, qsign, rsign, idle, go, div_zero, we_ok, last, ge;
    always_comb begin
        idle     = state == IDLE;
        div_zero = idle && start_div && !start_mult && !flush && opb == 32'd0;
        go       = idle && !flush && (start_mult || (start_div && opb != 32'd0));
        we_ok    = idle && !start_mult && !start_div;
        done     = ((state == MUL || state == FIX) && !flush) || div_zero;
        busy     = !idle;
        stall    = go || (busy && !done && !flush);
        last     = cnt == CW'(DIV_CYCLES - 1);
        abs_a    = (signed_op && opa[31]) ? -opa : opa;
        abs_b    = (signed_op && opb[31]) ? -opb : opb;
        // Low 64 bits of the sign/zero-extended product equal the exact 33x33 result.
        prod     = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
        shl      = {rem, quot[31]};
        sub      = shl - {1'b0, b};
        ge       = shl >= {1'b0, b};
        rem_nx   = ge ? sub[31:0] : shl[31:0];
        quot_nx  = {quot[30:0], ge};
        state_nx = flush ? IDLE
                 : idle ? (start_mult ? MUL : (start_div && opb != 32'd0) ? DIV : IDLE)
                 : (state == MUL || state == FIX) ? IDLE
                 : last ? FIX : DIV;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            a     <= '0;
            b     <= '0;
            rem   <= '0;
            quot  <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            qsign <= 1'b0;
            rsign <= 1'b0;
        end else begin
            state <= state_nx;
            if (go && start_mult) begin
                a   <= opa;
                b   <= opb;
                sgn <= signed_op;
            end else if (go) begin
                b     <= abs_b;
                quot  <= abs_a;
                rem   <= '0;
                cnt   <= '0;
                qsign <= signed_op & (opa[31] ^ opb[31]);
                rsign <= signed_op & opa[31];
            end
            if (state == DIV) begin
                rem  <= rem_nx;
                quot <= quot_nx;
                cnt  <= cnt + 1'b1;
            end
            if (div_zero) begin
                hi <= opa;
                lo <= '1;
            end else if (state == MUL && !flush) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end else if (state == FIX && !flush) begin
                hi <= rsign ? -rem : rem;
                lo <= qsign ? -quot : quot;
            end else if (we_ok) begin
                if (hilo_we[1]) hi <= hilo_wdata;
                if (hilo_we[0]) lo <= hilo_wdata;
            end
        end
    end
`ifdef HILO_FWD_EN
    assign hi_o = (we_ok && hilo_we[1]) ? hilo_wdata : hi;
    assign lo_o = (we_ok && hilo_we[0]) ? hilo_wdata : lo;
`else
    assign hi_o = hi;
    assign lo_o = lo;
`endif
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: random and directed checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
    logic clk = 1'b0, resetn = 1'b0, start_mult = 1'b0, start_div = 1'b0, signed_op = 1'b0, flush = 1'b0;
    logic [31:0] opa = '0, opb = '0, hilo_wdata = '0;
    logic [1:0] hilo_we = '0;
    logic stall, busy, done;
    logic [31:0] hi_o, lo_o;
    logic [31:0] m_hi = '0, m_lo = '0;
    int checks = 0, errors = 0;

    muldiv_ctrl #(.DIV_CYCLES(32)) dut (
        .clk(clk), .resetn(resetn), .start_mult(start_mult), .start_div(start_div),
        .signed_op(signed_op), .opa(opa), .opb(opb), .flush(flush), .hilo_we(hilo_we),
        .hilo_wdata(hilo_wdata), .stall(stall), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint p, q;
        p = s ? longint'($signed(x)) : longint'({32'b0, x});
        q = s ? longint'($signed(y)) : longint'({32'b0, y});
        return 64'(p * q);
    endfunction

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint p, q, qq, rr;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        p = s ? longint'($signed(x)) : longint'({32'b0, x});
        q = s ? longint'($signed(y)) : longint'({32'b0, y});
        qq = p / q;
        rr = p % q;
        return {rr[31:0], qq[31:0]};
    endfunction

    task automatic do_mul(input bit s, input logic [31:0] x, input logic [31:0] y, input logic [1:0] we);
        start_mult = 1'b1; signed_op = s; opa = x; opb = y; hilo_we = we; hilo_wdata = 32'h1234_5678;
        #1;
        chk("mul_stall_start", stall, 1);
        chk("mul_done_start", done, 0);
        tick;
        start_mult = 1'b0; hilo_we = '0; opa = $urandom; opb = $urandom; signed_op = ~s;
        #1;
        chk("mul_done", done, 1);
        chk("mul_stall_done", stall, 0);
        {m_hi, m_lo} = ref_mul(s, x, y);
        tick;
        chk("mul_hi", hi_o, m_hi);
        chk("mul_lo", lo_o, m_lo);
        chk("mul_idle", busy, 0);
    endtask

    task automatic do_div(input bit s, input logic [31:0] x, input logic [31:0] y);
        int n, bad;
        start_div = 1'b1; signed_op = s; opa = x; opb = y;
        #1;
        {m_hi, m_lo} = ref_div(s, x, y);
        if (y == 32'd0) begin
            chk("dz_stall", stall, 0);
            chk("dz_done", done, 1);
            tick;
            start_div = 1'b0;
            #1;
            chk("dz_hi", hi_o, m_hi);
            chk("dz_lo", lo_o, m_lo);
            chk("dz_idle", busy, 0);
        end else begin
            chk("div_stall_start", stall, 1);
            chk("div_done_start", done, 0);
            tick;
            start_div = 1'b0; opa = $urandom; opb = $urandom; signed_op = ~s;
            #1;
            n = 1;
            bad = 0;
            while (!done && n < 40) begin
                if (!stall) bad++;
                tick;
                n++;
            end
            chk("div_latency", n, 33);
            chk("div_stall_run", bad, 0);
            chk("div_stall_done", stall, 0);
            tick;
            chk("div_hi", hi_o, m_hi);
            chk("div_lo", lo_o, m_lo);
        end
    endtask

    task automatic do_write(input logic [1:0] we, input logic [31:0] d);
        hilo_we = we; hilo_wdata = d;
        #1;
`ifdef HILO_FWD_EN
        chk("wr_hi_same", hi_o, we[1] ? d : m_hi);
        chk("wr_lo_same", lo_o, we[0] ? d : m_lo);
`else
        chk("wr_hi_same", hi_o, m_hi);
        chk("wr_lo_same", lo_o, m_lo);
`endif
        tick;
        hilo_we = '0;
        if (we[1]) m_hi = d;
        if (we[0]) m_lo = d;
        #1;
        chk("wr_hi", hi_o, m_hi);
        chk("wr_lo", lo_o, m_lo);
    endtask

    task automatic abort_div(input bit use_reset);
        int dn;
        start_div = 1'b1; signed_op = 1'b1; opa = 32'hFFFF_FF00; opb = 32'd5;
        tick;
        start_div = 1'b0;
        repeat (9) tick;
        if (use_reset) resetn = 1'b0;
        else flush = 1'b1;
        #1;
        if (!use_reset) begin
            chk("flush_done", done, 0);
            chk("flush_stall", stall, 0);
        end
        tick;
        flush = 1'b0; resetn = 1'b1;
        if (use_reset) begin m_hi = '0; m_lo = '0; end
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_hi", hi_o, m_hi);
        chk("abort_lo", lo_o, m_lo);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            tick;
        end
        chk("abort_no_done", dn, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) tick;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        resetn = 1'b1;
        tick;
        do_mul(1'b1, 32'hFFFF_FFFD, 32'd7, 2'b00);
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div(1'b0, 32'd100, 32'd7);
        do_div(1'b0, 32'd1234, 32'd0);
        do_write(2'b10, 32'hCAFE_0001);
        do_write(2'b01, 32'hBEEF_0002);
        do_mul(1'b1, 32'hFFFF_FFFD, 32'd7, 2'b11);
        abort_div(1'b0);
        do_write(2'b11, 32'h5A5A_A5A5);
        abort_div(1'b1);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: do_mul(1'($urandom), $urandom, $urandom, 2'($urandom));
                1: do_div(1'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
                2: do_div(1'($urandom), $urandom, 32'($urandom_range(1, 300)));
                default: do_write(2'($urandom_range(1, 3)), $urandom);
            endcase
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
